// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe : parametrised, pipelined ALU with a valid/ready output stage.
//
// Operands A, B and the opcode are loaded from a shared bus by strobes
// (priority A > B > op). A start pulse snapshots them into a LATENCY-deep
// pipeline. The final stage is the output register. Backpressure from
// i_ready freezes the whole pipeline, so no accepted operation is ever lost.
//
// Optional feature macro: ALU_PIPE_SLT_EN (adds SLT / SLTU opcodes).
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_data               shared operand/opcode load bus
//   i_en_a/i_en_b/i_en_op load strobes
//   i_start              launch operation on current A/B/op
//   o_start_ready        i_start accepted this cycle when high
//   o_data               result
//   o_carry/o_zero/o_neg/o_ovf/o_err  flags aligned with o_data
//   o_valid / i_ready    output handshake
// -----------------------------------------------------------------------------
module alu_pipe #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6,
   parameter int LATENCY = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_en_a,
   input  logic               i_en_b,
   input  logic               i_en_op,
   input  logic               i_start,
   output logic               o_start_ready,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_carry,
   output logic               o_zero,
   output logic               o_neg,
   output logic               o_ovf,
   output logic               o_err,
   output logic               o_valid,
   input  logic               i_ready
);

   localparam int NB_SH  = $clog2(NB_DATA);
   // Result word: {err, ovf, neg, zero, carry, data}; a valid bit sits above it.
   localparam int NB_RES = NB_DATA + 5;

   localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'b100000);
   localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'b100010);
   localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'b100100);
   localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'b100101);
   localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'b100110);
   localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'b100111);
   localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(6'b000000);
   localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'b000010);
   localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'b000011);
`ifdef ALU_PIPE_SLT_EN
   localparam logic [NB_OP-1:0] OP_SLT  = NB_OP'(6'b101010);
   localparam logic [NB_OP-1:0] OP_SLTU = NB_OP'(6'b101011);
`endif

   // Full ALU evaluation: result plus all flags packed into one word.
   function automatic logic [NB_RES-1:0] alu_f(
      input logic [NB_DATA-1:0] a,
      input logic [NB_DATA-1:0] b,
      input logic [NB_OP-1:0]   op
   );
      logic [NB_DATA:0]   sum;
      logic [NB_DATA-1:0] res;
      logic [NB_SH-1:0]   sh;
      logic               carry;
      logic               ovf;
      logic               err;
      sh    = b[NB_SH-1:0];
      sum   = '0;
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      err   = 1'b0;
      case (op)
         OP_ADD: begin
            sum   = {1'b0, a} + {1'b0, b};
            res   = sum[NB_DATA-1:0];
            carry = sum[NB_DATA];
            ovf   = (a[NB_DATA-1] == b[NB_DATA-1]) && (res[NB_DATA-1] != a[NB_DATA-1]);
         end
         OP_SUB: begin
            res   = a - b;
            carry = (a >= b);
            ovf   = (a[NB_DATA-1] != b[NB_DATA-1]) && (res[NB_DATA-1] != a[NB_DATA-1]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOR: res = ~(a | b);
         OP_SLL: res = a << sh;
         OP_SRL: res = a >> sh;
         OP_SRA: res = $signed(a) >>> sh;
`ifdef ALU_PIPE_SLT_EN
         OP_SLT:  res = {{(NB_DATA-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: res = {{(NB_DATA-1){1'b0}}, (a < b)};
`endif
         default: err = 1'b1;
      endcase
      return {err, ovf, res[NB_DATA-1], (res == '0), carry, res};
   endfunction

   logic [NB_DATA-1:0] r_a;
   logic [NB_DATA-1:0] r_b;
   logic [NB_OP-1:0]   r_op;
   logic [NB_RES:0]    r_out;
   logic [NB_RES:0]    w_head;
   logic               w_adv;
   logic               w_launch;

   // Whole pipeline moves only when the output register can take new data.
   assign w_adv    = !r_out[NB_RES] || i_ready;
   assign w_launch = i_start && w_adv;

   // Operand/opcode load registers, one strobe wins per edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a  <= '0;
         r_b  <= '0;
         r_op <= '0;
      end else if (i_en_a) begin
         r_a  <= i_data;
      end else if (i_en_b) begin
         r_b  <= i_data;
      end else if (i_en_op) begin
         r_op <= i_data[NB_OP-1:0];
      end
   end

   generate
      if (LATENCY == 1) begin : g_lat1
         // Single stage: evaluate straight from the load registers.
         assign w_head = {w_launch, alu_f(r_a, r_b, r_op)};
      end else begin : g_latn
         logic               r_s1_vld;
         logic [NB_DATA-1:0] r_s1_a;
         logic [NB_DATA-1:0] r_s1_b;
         logic [NB_OP-1:0]   r_s1_op;
         logic [NB_RES:0]    w_s1_res;

         // Stage 1 snapshot of the operands taken at launch.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_s1_vld <= 1'b0;
               r_s1_a   <= '0;
               r_s1_b   <= '0;
               r_s1_op  <= '0;
            end else if (w_adv) begin
               r_s1_vld <= w_launch;
               r_s1_a   <= r_a;
               r_s1_b   <= r_b;
               r_s1_op  <= r_op;
            end
         end

         assign w_s1_res = {r_s1_vld, alu_f(r_s1_a, r_s1_b, r_s1_op)};

         if (LATENCY == 2) begin : g_direct
            assign w_head = w_s1_res;
         end else begin : g_mid
            logic [NB_RES:0] r_mid [LATENCY-2];

            // Delay line carrying result and flags together.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
               if (!i_rst_n) begin
                  for (int i = 0; i < LATENCY - 2; i++) r_mid[i] <= '0;
               end else if (w_adv) begin
                  r_mid[0] <= w_s1_res;
                  for (int i = 1; i < LATENCY - 2; i++) r_mid[i] <= r_mid[i-1];
               end
            end

            assign w_head = r_mid[LATENCY-3];
         end
      end
   endgenerate

   // Output register; bubbles are stored as all-zero so idle outputs read 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out <= '0;
      end else if (w_adv) begin
         r_out <= w_head[NB_RES] ? w_head : '0;
      end
   end

   assign o_start_ready = w_adv;
   assign o_valid       = r_out[NB_RES];
   assign o_err         = r_out[NB_DATA+4];
   assign o_ovf         = r_out[NB_DATA+3];
   assign o_neg         = r_out[NB_DATA+2];
   assign o_zero        = r_out[NB_DATA+1];
   assign o_carry       = r_out[NB_DATA];
   assign o_data        = r_out[NB_DATA-1:0];

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe : table-driven bench with a scoreboard queue for alu_pipe
// (NB_DATA=8, NB_OP=6, LATENCY=2).
// -----------------------------------------------------------------------------
module tb_alu_pipe;

   localparam int LAT = 2;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [5:0]  op;
      logic [12:0] exp;
   } vec_t;

   typedef struct {
      logic [12:0] exp;
      int          cyc;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i_data;
   logic       i_en_a, i_en_b, i_en_op, i_start, i_ready;
   logic       o_start_ready, o_carry, o_zero, o_neg, o_ovf, o_err, o_valid;
   logic [7:0] o_data;
   logic [12:0] w_out;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          cyc   = 0;
   int          base;
   logic        lat_chk = 1'b1;
   logic [12:0] exp_cur = '0;
   logic        hold_vld = 1'b0;
   logic [13:0] hold_val = '0;
   sb_t         sb[$];
   sb_t         e;
   vec_t        vt[20];

   alu_pipe #(.NB_DATA(8), .NB_OP(6), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data),
      .i_en_a(i_en_a), .i_en_b(i_en_b), .i_en_op(i_en_op),
      .i_start(i_start), .o_start_ready(o_start_ready),
      .o_data(o_data), .o_carry(o_carry), .o_zero(o_zero), .o_neg(o_neg),
      .o_ovf(o_ovf), .o_err(o_err), .o_valid(o_valid), .i_ready(i_ready)
   );

   assign w_out = {o_err, o_ovf, o_neg, o_zero, o_carry, o_data};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [12:0] X(input logic [7:0] d, input logic c, input logic z,
                                     input logic n, input logic v, input logic er);
      return {er, v, n, z, c, d};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ops(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      i_data = a;          i_en_a  = 1'b1; cycle(); i_en_a  = 1'b0;
      i_data = b;          i_en_b  = 1'b1; cycle(); i_en_b  = 1'b0;
      i_data = {2'b00, op}; i_en_op = 1'b1; cycle(); i_en_op = 1'b0;
      i_data = 8'h00;
   endtask

   task automatic pulse_start(input logic [12:0] expv);
      exp_cur = expv;
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check(name, sb.size(), 0);
   endtask

   // Scoreboard monitor: pop/compare on output handshake, push on accepted start.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         hold_vld = 1'b0;
      end else begin
         if (hold_vld) begin
            n_vec++;
            if ({o_valid, w_out} !== hold_val) begin
               n_err++;
               $display("FAIL hold: got %h expected %h", {o_valid, w_out}, hold_val);
            end
         end
         hold_vld = o_valid && !i_ready;
         hold_val = {o_valid, w_out};
         if (o_valid && i_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_result: got %h expected none", w_out);
            end else begin
               e = sb.pop_front();
               if (w_out !== e.exp) begin
                  n_err++;
                  $display("FAIL result: got %h expected %h", w_out, e.exp);
               end
               if (lat_chk && (cyc - e.cyc != LAT)) begin
                  n_err++;
                  $display("FAIL latency: got %0d expected %0d", cyc - e.cyc, LAT);
               end
            end
         end
         if (i_start && o_start_ready) begin
            sb.push_back('{exp_cur, cyc});
            n_acc++;
         end
      end
   end

   initial begin
      vt[0]  = '{8'h7F, 8'h01, 6'b100000, X(8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
      vt[1]  = '{8'hFF, 8'h01, 6'b100000, X(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
      vt[2]  = '{8'h03, 8'h05, 6'b100010, X(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
      vt[3]  = '{8'h05, 8'h03, 6'b100010, X(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      vt[4]  = '{8'h90, 8'h03, 6'b000010, X(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
      vt[5]  = '{8'h90, 8'h03, 6'b000011, X(8'hF2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
      vt[6]  = '{8'h90, 8'h03, 6'b000000, X(8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
      vt[7]  = '{8'h90, 8'h0B, 6'b000010, X(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
      vt[8]  = '{8'hF0, 8'h3C, 6'b100100, X(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
      vt[9]  = '{8'hF0, 8'h0C, 6'b100101, X(8'hFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
      vt[10] = '{8'hFF, 8'hFF, 6'b100110, X(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
      vt[11] = '{8'h00, 8'h00, 6'b100111, X(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
      vt[12] = '{8'h80, 8'h01, 6'b100010, X(8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)};
      vt[13] = '{8'h80, 8'h80, 6'b100000, X(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)};
      vt[14] = '{8'h12, 8'h34, 6'b111111, X(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
`ifdef ALU_PIPE_SLT_EN
      vt[15] = '{8'hFE, 8'h01, 6'b101010, X(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
      vt[16] = '{8'hFE, 8'h01, 6'b101011, X(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
`else
      vt[15] = '{8'hFE, 8'h01, 6'b101010, X(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
      vt[16] = '{8'hFE, 8'h01, 6'b101011, X(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
`endif
      vt[17] = '{8'h55, 8'h08, 6'b000000, X(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
      vt[18] = '{8'h7F, 8'h07, 6'b000011, X(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
      vt[19] = '{8'h07, 8'h07, 6'b100010, X(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};

      rst_n = 1'b0; i_data = 8'h00; i_en_a = 1'b0; i_en_b = 1'b0; i_en_op = 1'b0;
      i_start = 1'b0; i_ready = 1'b1;
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();
      check("reset_valid", o_valid, 1'b0);
      check("reset_outputs", w_out, 13'h0000);
      check("reset_start_ready", o_start_ready, 1'b1);

      // Reset while an ADD is in flight: it must vanish.
      load_ops(8'h7F, 8'h01, 6'b100000);
      exp_cur = X(8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      rst_n   = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("midflight_valid", o_valid, 1'b0);
         check("midflight_outputs", w_out, 13'h0000);
      end

      // Table-driven single operations.
      for (int i = 0; i < 20; i++) begin
         load_ops(vt[i].a, vt[i].b, vt[i].op);
         pulse_start(vt[i].exp);
      end
      drain("table_drain");

      // Strobe priority: all strobes together load only A.
      load_ops(8'h10, 8'h03, 6'b100000);
      i_data = 8'h22; i_en_a = 1'b1; i_en_b = 1'b1; i_en_op = 1'b1;
      cycle();
      i_en_a = 1'b0;
      i_data = 8'h24;
      cycle();
      i_en_b = 1'b0; i_en_op = 1'b0;
      pulse_start(X(8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drain("priority_drain");

      // Backpressure: four back-to-back starts with the consumer stalled;
      // the strobe on A in the same cycle only affects the next start.
      lat_chk = 1'b0;
      load_ops(8'h10, 8'h01, 6'b100000);
      i_ready = 1'b0;
      base = n_acc;
      for (int k = 0; k < 4; k++) begin
         exp_cur = X(8'h11 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         i_start = 1'b1; i_en_a = 1'b1; i_data = 8'h11 + 8'(k);
         cycle();
      end
      i_start = 1'b0; i_en_a = 1'b0; i_data = 8'h00;
      repeat (3) cycle();
      check("bp_start_ready", o_start_ready, 1'b0);
      check("bp_valid", o_valid, 1'b1);
      check("bp_head_data", o_data, 8'h11);
      check("bp_accepted", n_acc - base, LAT);
      i_ready = 1'b1;
      drain("bp_drain");
      repeat (3) cycle();
      lat_chk = 1'b1;

      // Full throughput: one start per cycle with i_ready held high.
      load_ops(8'h01, 8'h01, 6'b100000);
      base = n_acc;
      for (int k = 0; k < 5; k++) begin
         exp_cur = X(8'h02 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         i_start = 1'b1; i_en_a = 1'b1; i_data = 8'h02 + 8'(k);
         cycle();
      end
      i_start = 1'b0; i_en_a = 1'b0; i_data = 8'h00;
      check("tput_accepted", n_acc - base, 5);
      drain("tput_drain");
      repeat (2) cycle();
      check("idle_valid", o_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit single-cycle ALU.
- Operands A and B and the opcode are loaded from a shared input bus by strobes. A start pulse snapshots them into a LATENCY-deep pipeline.
- The result and flags leave through a valid/ready output register that applies backpressure to the whole pipeline.
- Sits between the operand-loading front end (switches/UART bridge) and the result consumer.

Parameters:
NB_DATA, 8, operand/result width; must be >= 6 and a power of two
NB_OP, 6, opcode width; opcode is taken from i_data[NB_OP-1:0]
LATENCY, 2, cycles from accepted i_start to o_valid; legal range 1..4

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous reset, active-low
i_data  in  NB_DATA  shared load bus
i_en_a  in  1  load A from i_data
i_en_b  in  1  load B from i_data
i_en_op  in  1  load opcode from i_data[NB_OP-1:0]
i_start  in  1  launch operation on current A/B/op
o_start_ready  out  1  i_start is accepted this cycle when high
o_data  out  NB_DATA  result
o_carry  out  1  carry / no-borrow flag
o_zero  out  1  result == 0
o_neg  out  1  result MSB
o_ovf  out  1  signed overflow (ADD/SUB only, else 0)
o_err  out  1  opcode not recognised
o_valid  out  1  result/flags valid
i_ready  in  1  consumer accepts result

Behaviour:
- Reset (i_rst_n low, async):
  - A, B, op, all pipeline stages and the output register are cleared to 0.
  - o_valid = 0, all flags = 0, o_data = 0.
  - An operation in flight is discarded and no o_valid is produced for it.
- Load registers:
  - On a clock edge, the strobes load in priority i_en_a > i_en_b > i_en_op; only the highest asserted strobe loads.
  - Each register holds its value until it is loaded again.
- Launch:
  - advance = !o_valid || i_ready; o_start_ready = advance.
  - When i_start && advance, the current A/B/op are snapshotted into stage 1 with valid = 1.
  - A strobe in the same cycle as i_start affects the next operation only; the snapshot uses the pre-edge values.
  - i_start while !advance is ignored (dropped, not queued).
- Pipeline:
  - The result is computed combinationally from stage 1 and carried through LATENCY-1 further registers.
  - The last stage is the output register.
  - All stages move only when advance = 1; otherwise they hold, so no valid data is ever lost.
  - Throughput: one operation per cycle while i_ready is held high.
  - Result appears LATENCY cycles after acceptance.
- Output handshake:
  - o_valid with its data and flags stays stable until the cycle where o_valid && i_ready.
  - If i_start is accepted in that same cycle, the next result follows on schedule.
- Opcodes (result width NB_DATA; SH = B[log2(NB_DATA)-1:0]):
  - 100000 ADD: {carry, res} = A + B; ovf = signed overflow.
  - 100010 SUB: res = A - B; carry = (A >= B) unsigned; ovf = signed overflow.
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 000000 SLL: A << SH.
  - 000010 SRL: A >> SH, logical.
  - 000011 SRA: A >>> SH, arithmetic; the sign bit is replicated.
  - Logic and shift ops: carry = 0, ovf = 0.
  - Any other opcode: res = 0, err = 1, zero = 1, carry = ovf = neg = 0.
- Flags are computed together with the result and stay aligned with it through every stage.

Optional Feature:
- Macro: ALU_PIPE_SLT_EN.
- Defined: adds 101010 SLT (res = 1 if signed A < B, else 0) and 101011 SLTU (unsigned compare). Both set carry = ovf = 0; zero and neg follow the result.
- Undefined: both opcodes decode as unrecognised (err = 1, res = 0).

Test Plan:
1. Reset mid-flight: load A=0x7F, B=0x01, op=ADD; pulse i_start; drop i_rst_n one cycle later -> o_valid stays 0 after release, all outputs 0.
2. ADD overflow (LATENCY=2, i_ready=1): A=0x7F, B=0x01, ADD -> 2 cycles later o_data=0x80, o_neg=1, o_ovf=1, o_carry=0, o_zero=0; a second ADD with A=0xFF, B=0x01 -> o_data=0x00, o_carry=1, o_zero=1.
3. SUB borrow: A=0x03, B=0x05 -> o_data=0xFE, o_carry=0, o_neg=1; then A=0x05, B=0x03 -> o_data=0x02, o_carry=1.
4. Shifts: A=0x90, B=0x03 -> SRL gives 0x12, SRA gives 0xF2, SLL gives 0x80 (shift uses B[2:0] only; B=0x0B also gives SRL 0x12).
5. Backpressure: 4 back-to-back i_start with i_ready=0 -> o_start_ready falls once the pipeline fills; o_data stays stable; raising i_ready drains the results in order with no loss or duplication; starts issued while o_start_ready=0 produce no result.
6. Opcode 0x3F -> o_err=1, o_data=0, o_zero=1. Opcode 101010 with A=0xFE, B=0x01 -> 0x01 when ALU_PIPE_SLT_EN is defined, o_err=1 otherwise.
